// File: rtl/sync_detect_if.sv
// Sync-detector signal bundle: raw sync inputs plus measured timing and status.
interface sync_detect_if;
  logic        hsync_in;
  logic        vsync_in;
  logic [15:0] hcount;
  logic [15:0] vcount;
  logic [15:0] h_total;
  logic [15:0] h_width;
  logic [15:0] v_total;
  logic [15:0] v_width;
  logic        line_start;
  logic        frame_start;
  logic        locked;

  modport master (
    output hsync_in, vsync_in,
    input  hcount, vcount, h_total, h_width, v_total, v_width,
    input  line_start, frame_start, locked
  );

  modport slave (
    input  hsync_in, vsync_in,
    output hcount, vcount, h_total, h_width, v_total, v_width,
    output line_start, frame_start, locked
  );
endinterface

// File: rtl/sync_detect.sv
// Video sync detector: measures line/frame geometry from asynchronous hsync/vsync and
// reports lock once the geometry has repeated for LOCK_FRAMES frames.
module sync_detect #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter logic [15:0] H_TIMEOUT   = 16'hFFFF
) (
  input logic          clk,
  input logic          rst,
  sync_detect_if.slave bus
);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  localparam logic [2:0]  LockCnt = 3'(LOCK_FRAMES);
  localparam logic [15:0] CntMax  = 16'hFFFF;

  logic        hs_meta_q, hs_s_q, hs_d_q;
  logic        vs_meta_q, vs_s_q, vs_d_q;
  logic        hs_rise, hs_fall, vs_rise, vs_fall;
  logic [15:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic [15:0] h_total_q, h_total_d, h_width_q, h_width_d;
  logic [15:0] v_total_q, v_total_d, v_width_q, v_width_d;
  logic        h_valid_q, h_valid_d, v_valid_q, v_valid_d;
  logic        h_err_q, h_err_d, h_err_now, h_line_err;
  logic        line_start_q, frame_start_q;
  logic        timeout, h_upd, v_upd, eval;
  logic [15:0] hcount_inc, v_meas;
  logic [63:0] cur_meas, snap_q, snap_d;
  logic        snap_valid_q, snap_valid_d;
  logic [2:0]  match_cnt_q, match_cnt_d;
  state_e      state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_meta_q <= 1'b0;
      hs_s_q    <= 1'b0;
      hs_d_q    <= 1'b0;
      vs_meta_q <= 1'b0;
      vs_s_q    <= 1'b0;
      vs_d_q    <= 1'b0;
    end else begin
      hs_meta_q <= bus.hsync_in;
      hs_s_q    <= hs_meta_q;
      hs_d_q    <= hs_s_q;
      vs_meta_q <= bus.vsync_in;
      vs_s_q    <= vs_meta_q;
      vs_d_q    <= vs_s_q;
    end
  end

  assign hs_rise = hs_s_q & ~hs_d_q;
  assign hs_fall = ~hs_s_q & hs_d_q;
  assign vs_rise = vs_s_q & ~vs_d_q;
  assign vs_fall = ~vs_s_q & vs_d_q;

  assign timeout    = (hcount_q == H_TIMEOUT);
  assign hcount_inc = hcount_q + 16'd1;
  // Measurements are suppressed on the timeout cycle so hcount+1 can never wrap.
  assign h_upd      = h_valid_q & ~timeout;
  assign v_upd      = v_valid_q & ~timeout;
  assign h_line_err = hs_rise & h_upd & (hcount_inc != h_total_q);
  assign h_err_now  = h_err_q | h_line_err;
  // Line count including a line starting on this very cycle.
  assign v_meas     = (hs_rise && vcount_q != CntMax) ? vcount_q + 16'd1 : vcount_q;
  assign eval       = vs_rise & v_upd;
  assign cur_meas   = {h_total_q, h_width_q, v_meas, v_width_q};

  always_comb begin
    hcount_d  = hcount_q;
    vcount_d  = v_meas;
    h_total_d = h_total_q;
    h_width_d = h_width_q;
    v_total_d = v_total_q;
    v_width_d = v_width_q;
    h_valid_d = h_valid_q;
    v_valid_d = v_valid_q;
    h_err_d   = h_err_now;

    if (hs_rise) begin
      hcount_d  = 16'd0;
      h_valid_d = 1'b1;
      if (h_upd) h_total_d = hcount_inc;
    end else begin
      if (!timeout) hcount_d = hcount_inc;
      if (timeout) h_valid_d = 1'b0;
    end
    if (hs_fall && h_upd) h_width_d = hcount_inc;

    if (vs_rise) begin
      vcount_d  = 16'd0;
      v_valid_d = 1'b1;
      h_err_d   = 1'b0;
      if (v_upd) v_total_d = v_meas;
    end
    if (vs_fall && v_upd) v_width_d = v_meas;

    if (timeout) begin
      v_valid_d = 1'b0;
      h_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= 16'd0;
      vcount_q      <= 16'd0;
      h_total_q     <= 16'd0;
      h_width_q     <= 16'd0;
      v_total_q     <= 16'd0;
      v_width_q     <= 16'd0;
      h_valid_q     <= 1'b0;
      v_valid_q     <= 1'b0;
      h_err_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      h_total_q     <= h_total_d;
      h_width_q     <= h_width_d;
      v_total_q     <= v_total_d;
      v_width_q     <= v_width_d;
      h_valid_q     <= h_valid_d;
      v_valid_q     <= v_valid_d;
      h_err_q       <= h_err_d;
      line_start_q  <= hs_rise;
      frame_start_q <= vs_rise;
    end
  end

  // Lock FSM: one evaluation per frame, against the geometry snapshot of the previous one.
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    match_cnt_d  = match_cnt_q;

    if (timeout) begin
      state_d      = StSearch;
      snap_valid_d = 1'b0;
      match_cnt_d  = 3'd0;
    end else if (eval) begin
      if (snap_valid_q && (cur_meas == snap_q) && !h_err_now) begin
        match_cnt_d = (match_cnt_q == LockCnt) ? LockCnt : match_cnt_q + 3'd1;
        state_d     = (match_cnt_d == LockCnt) ? StLocked : StVerify;
      end else begin
        snap_d       = cur_meas;
        snap_valid_d = 1'b1;
        match_cnt_d  = 3'd0;
        state_d      = StVerify;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StSearch;
      snap_q       <= 64'd0;
      snap_valid_q <= 1'b0;
      match_cnt_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      match_cnt_q  <= match_cnt_d;
    end
  end

  assign bus.hcount      = hcount_q;
  assign bus.vcount      = vcount_q;
  assign bus.h_total     = h_total_q;
  assign bus.h_width     = h_width_q;
  assign bus.v_total     = v_total_q;
  assign bus.v_width     = v_width_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.locked      = (state_q == StLocked);

endmodule

// File: tb/tb_sync_detect.sv
// Directed bench for sync_detect: 800x600 timing, lock, line error, coincident edges,
// mid-frame reset and hsync timeout, with per-frame expectations held in a scoreboard.
module tb_sync_detect;

  localparam int P = 10;

  logic clk = 1'b0;
  logic rst;

  sync_detect_if bus ();

  sync_detect #(
    .LOCK_FRAMES(2),
    .H_TIMEOUT  (16'hFFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #(P / 2) clk = ~clk;

  typedef struct packed {
    logic [15:0] h_total;
    logic [15:0] h_width;
    logic [15:0] v_total;
    logic [15:0] v_width;
    logic        locked;
    logic        coinc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   voff;
  logic chk_line1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] ht, input logic [15:0] hw,
                              input logic [15:0] vt, input logic [15:0] vw,
                              input logic lk, input logic co);
    exp_t e;
    e.h_total = ht;
    e.h_width = hw;
    e.v_total = vt;
    e.v_width = vw;
    e.locked  = lk;
    e.coinc   = co;
    return e;
  endfunction

  // One line starting at a falling clock edge; vsync takes vs at offset voff (0 = with hsync).
  task automatic drive_line(input int len, input logic vs);
    bus.hsync_in = 1'b1;
    if (voff == 0) begin
      bus.vsync_in = vs;
      #(128 * P);
      bus.hsync_in = 1'b0;
      #((len - 128) * P);
    end else begin
      #(128 * P);
      bus.hsync_in = 1'b0;
      #((voff - 128) * P);
      bus.vsync_in = vs;
      #((len - voff) * P);
    end
  endtask

  task automatic drive_frame(input int nlines, input int long_idx, input exp_t e);
    for (int l = 0; l < nlines; l++) begin
      if (l == 0) sb_q.push_back(e);
      drive_line((l == long_idx) ? 1057 : 1056, l < 4);
      if (chk_line1 && l == 1) begin
        chk("line_end_hcount", bus.hcount, 16'd1053);
        chk("line_end_vcount", bus.vcount, 16'd1);
        chk_line1 = 1'b0;
      end
      if (long_idx >= 0 && l == long_idx + 1) begin
        chk("long_line_h_total", bus.h_total, 16'd1057);
        chk("long_line_h_err", 16'(dut.h_err_q), 16'd1);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hcount"}, bus.hcount, 16'd0);
    chk({tag, "_vcount"}, bus.vcount, 16'd0);
    chk({tag, "_h_total"}, bus.h_total, 16'd0);
    chk({tag, "_h_width"}, bus.h_width, 16'd0);
    chk({tag, "_v_total"}, bus.v_total, 16'd0);
    chk({tag, "_v_width"}, bus.v_width, 16'd0);
    chk({tag, "_line_start"}, 16'(bus.line_start), 16'd0);
    chk({tag, "_frame_start"}, 16'(bus.frame_start), 16'd0);
    chk({tag, "_locked"}, 16'(bus.locked), 16'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    chk_line1    = 1'b0;
    voff         = 500;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (bus.frame_start === 1'b1) begin
            chk("sb_has_entry", 16'(sb_q.size() != 0), 16'd1);
            if (sb_q.size() != 0) begin
              e = sb_q.pop_front();
              chk("fs_vcount", bus.vcount, 16'd0);
              chk("fs_h_total", bus.h_total, e.h_total);
              chk("fs_h_width", bus.h_width, e.h_width);
              chk("fs_v_total", bus.v_total, e.v_total);
              chk("fs_v_width", bus.v_width, e.v_width);
              chk("fs_locked", 16'(bus.locked), 16'(e.locked));
              chk("fs_line_start", 16'(bus.line_start), 16'(e.coinc));
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Acquisition with vsync mid-line, then a single 1057-clock line while locked.
    chk_line1 = 1'b1;
    drive_frame(628, -1, mk(16'd0, 16'd128, 16'd0, 16'd0, 1'b0, 1'b0));
    drive_frame(628, -1, mk(16'd1056, 16'd128, 16'd628, 16'd4, 1'b0, 1'b0));
    drive_frame(628, -1, mk(16'd1056, 16'd128, 16'd628, 16'd4, 1'b0, 1'b0));
    drive_frame(628, 300, mk(16'd1056, 16'd128, 16'd628, 16'd4, 1'b1, 1'b0));
    drive_frame(628, -1, mk(16'd1056, 16'd128, 16'd628, 16'd4, 1'b0, 1'b0));
    drive_frame(628, -1, mk(16'd1056, 16'd128, 16'd628, 16'd4, 1'b0, 1'b0));
    drive_frame(300, -1, mk(16'd1056, 16'd128, 16'd628, 16'd4, 1'b1, 1'b0));

    // One-clock reset mid-frame while locked.
    chk("pre_reset_locked", 16'(bus.locked), 16'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    #(P - 1);
    rst = 1'b0;

    // Re-acquisition with vsync rising together with hsync.
    voff      = 0;
    chk_line1 = 1'b1;
    drive_frame(628, -1, mk(16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1));
    drive_frame(628, -1, mk(16'd1056, 16'd128, 16'd628, 16'd4, 1'b0, 1'b1));
    drive_frame(628, -1, mk(16'd1056, 16'd128, 16'd628, 16'd4, 1'b0, 1'b1));
    drive_frame(10, -1, mk(16'd1056, 16'd128, 16'd628, 16'd4, 1'b1, 1'b1));
    chk("pre_timeout_locked", 16'(bus.locked), 16'd1);

    // Loss of hsync: hcount saturates, lock drops, measurements hold.
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    #(70000 * P);
    chk("timeout_hcount", bus.hcount, 16'hFFFF);
    chk("timeout_locked", 16'(bus.locked), 16'd0);
    chk("timeout_h_total", bus.h_total, 16'd1056);
    drive_line(1000, 1'b0);
    chk("first_rise_h_total", bus.h_total, 16'd1056);
    drive_line(1056, 1'b0);
    chk("second_rise_h_total", bus.h_total, 16'd1000);
    chk("post_timeout_locked", 16'(bus.locked), 16'd0);

    repeat (4) @(negedge clk);
    chk("sb_empty", 16'(sb_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_detect.md
SYNC_DETECT -- requirements
Module: sync_detect

Interface
REQ-001 The block SHALL have parameter LOCK_FRAMES, default 2: consecutive matching frames required to assert locked (1..7).
REQ-002 The block SHALL have parameter H_TIMEOUT, default 16'hFFFF: hcount value treated as loss of horizontal sync.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock (40 MHz dot clock); all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port hsync_in, input, 1 bit: active-high horizontal sync, asynchronous to clk.
REQ-006 The block SHALL have port vsync_in, input, 1 bit: active-high vertical sync, asynchronous to clk.
REQ-007 The block SHALL have port hcount, output, 16 bits: clocks since the last detected hsync rise.
REQ-008 The block SHALL have port vcount, output, 16 bits: hsync rises since the last detected vsync rise.
REQ-009 The block SHALL have ports h_total, h_width, v_total and v_width, outputs, 16 bits each: measured line period (clocks), hsync pulse width (clocks), frame period (lines) and vsync width (lines).
REQ-010 The block SHALL have ports line_start and frame_start, outputs, 1 bit each: single-cycle pulses on a detected hsync rise and a detected vsync rise.
REQ-011 The block SHALL have port locked, output, 1 bit: timing is stable.

Function
REQ-012 Each sync input SHALL pass through a 2-flop synchronizer (stage s) plus one delay flop (d).
- rise = s & ~d; fall = ~s & d.
- A pin edge is detected 3 clocks later, at the earliest.
REQ-013 On hs_rise, hcount SHALL load 0; otherwise it increments and saturates at H_TIMEOUT.
REQ-014 On hs_rise with h_valid set, h_total SHALL load hcount+1; the first hs_rise after reset or timeout only sets h_valid.
REQ-015 On hs_fall with h_valid set, h_width SHALL load hcount+1, which equals the synchronized high time in clocks.
REQ-016 On hs_rise, vcount SHALL increment, saturating at 16'hFFFF; on vs_rise, vcount SHALL load 0, and vs_rise wins over a simultaneous hs_rise.
REQ-017 On vs_rise with v_valid set, v_total SHALL load vcount + hs_rise; on vs_fall with v_valid set, v_width SHALL load vcount + hs_rise; the first vs_rise only sets v_valid.
REQ-018 line_start SHALL equal registered hs_rise and frame_start SHALL equal registered vs_rise, each high exactly one cycle, aligned with the counter reload.
REQ-019 An h_err flag SHALL be set when an hs_rise with h_valid gives hcount+1 different from the current h_total; it is cleared at each vs_rise after evaluation.
REQ-020 The lock FSM SHALL have states SEARCH, VERIFY and LOCKED, evaluated only on vs_rise with v_valid.
- It compares {h_total, h_width, new v_total, v_width} against snapshot registers.
- If snap_valid is 0: snapshot loads, snap_valid=1, match_cnt=0, state VERIFY.
- If values are equal and h_err=0: match_cnt++ (saturating at LOCK_FRAMES); state becomes LOCKED when match_cnt reaches LOCK_FRAMES.
- If values differ or h_err=1: snapshot reloads, match_cnt=0, state VERIFY.
REQ-021 locked SHALL be 1 only in state LOCKED, updated on the cycle after the evaluating vs_rise.
REQ-022 When hcount reaches H_TIMEOUT, the block SHALL take the timeout action.
- h_valid, v_valid, snap_valid, h_err and match_cnt clear.
- State returns to SEARCH and locked drops the next cycle.
- Measurement outputs hold their last values.
REQ-023 All arithmetic SHALL be unsigned 16-bit, with no wrap: counters saturate.

Reset
REQ-024 On assertion of rst, the block SHALL reset asynchronously.
- All synchronizer flops, hcount, vcount, h_total, h_width, v_total and v_width go to 0.
- line_start, frame_start and locked go to 0.
- FSM goes to SEARCH; all valid flags, h_err and match_cnt clear.
REQ-025 Reset asserted mid-frame SHALL discard partial measurements, and after release the block SHALL re-acquire exactly as from power-up.

Verification
REQ-026 The bench SHALL drive standard 800x600 timing (line 1056 clk, hsync 128 clk, frame 628 lines, vsync 4 lines); required response: h_total=1056, h_width=128, v_total=628, v_width=4.
REQ-027 The bench SHALL check lock acquisition under the same stimulus with LOCK_FRAMES=2; required response: locked=0 through the 3rd vs_rise and locked=1 one cycle after the 4th vs_rise.
REQ-028 The bench SHALL change one line to 1057 clk while locked; required response: h_err is set, locked drops after the next vs_rise, and locked re-asserts after 2 further clean frames.
REQ-029 The bench SHALL hold hsync_in low after lock; required response: hcount saturates at 16'hFFFF, locked=0 and h_total stays 1056; the first hs_rise after that produces no h_total update.
REQ-030 The bench SHALL force vsync_in rising on the same synchronized cycle as hsync_in rising; required response: vcount=0, v_total counts that line, and frame_start and line_start are both 1 on the same cycle.
REQ-031 The bench SHALL assert rst for 1 clk mid-frame while locked; required response: all outputs are 0 asynchronously, and locked returns one cycle after the 4th vs_rise after release.
